// File: rtl/xf100_exu_alu_arb_pkg.sv
// ----------------------------------------------------------------------------
// xf100_exu_alu_arb_pkg
// Shared widths, ALU info-bus layout and the ALU opcode enum for the EXU
// ALU arbiter slice. alu_info() packs an opcode and the op2-is-immediate flag
// into an ALU info word.
// ----------------------------------------------------------------------------
package xf100_exu_alu_arb_pkg;

  localparam int XF100_XLEN          = 32;
  localparam int XF100_RFIDX_WIDTH   = 5;
  localparam int XF100_ALU_ARB_DEPTH = 2;

  // ALU info bus: [3:0] opcode, [4] second operand taken from imm
  localparam int ALU_INFO_OP_LSB = 0;
  localparam int ALU_INFO_OP_W   = 4;
  localparam int ALU_INFO_OP2IMM = 4;
  localparam int ALU_INFO_WIDTH  = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_AND  = 4'd6,
    ALU_LUI  = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10
  } alu_op_e;

  function automatic logic [ALU_INFO_WIDTH-1:0] alu_info(input alu_op_e op, input logic op2_imm);
    logic [ALU_INFO_WIDTH-1:0] info;
    info = '0;
    info[ALU_INFO_OP_LSB +: ALU_INFO_OP_W] = op;
    info[ALU_INFO_OP2IMM] = op2_imm;
    return info;
  endfunction

endpackage

// File: rtl/xf100_exu_alu_arb_if.sv
// ----------------------------------------------------------------------------
// xf100_exu_alu_arb_if
// Bundles the two ALU request channels (r0 = decode issue, r1 = helper) and
// the writeback-side result channel.
//   master : requesters + writeback consumer (drives requests, wbck_ready)
//   slave  : the arbiter (drives rN_ready, wbck_*, arb_busy)
// ----------------------------------------------------------------------------
interface xf100_exu_alu_arb_if
  import xf100_exu_alu_arb_pkg::*;
#(
  parameter int XLEN    = XF100_XLEN,
  parameter int RFIDX_W = XF100_RFIDX_WIDTH,
  parameter int INFO_W  = ALU_INFO_WIDTH
);
  logic               r0_valid;
  logic               r0_ready;
  logic [INFO_W-1:0]  r0_info;
  logic [XLEN-1:0]    r0_rs1;
  logic [XLEN-1:0]    r0_rs2;
  logic [XLEN-1:0]    r0_imm;
  logic               r0_rd_en;
  logic [RFIDX_W-1:0] r0_rdidx;

  logic               r1_valid;
  logic               r1_ready;
  logic [INFO_W-1:0]  r1_info;
  logic [XLEN-1:0]    r1_rs1;
  logic [XLEN-1:0]    r1_rs2;
  logic [XLEN-1:0]    r1_imm;
  logic               r1_rd_en;
  logic [RFIDX_W-1:0] r1_rdidx;

  logic               wbck_valid;
  logic               wbck_ready;
  logic               wbck_en;
  logic [XLEN-1:0]    wbck_data;
  logic [RFIDX_W-1:0] wbck_rdidx;
  logic               wbck_src;
  logic               arb_busy;

  modport master (
    output r0_valid, r0_info, r0_rs1, r0_rs2, r0_imm, r0_rd_en, r0_rdidx,
    output r1_valid, r1_info, r1_rs1, r1_rs2, r1_imm, r1_rd_en, r1_rdidx,
    output wbck_ready,
    input  r0_ready, r1_ready,
    input  wbck_valid, wbck_en, wbck_data, wbck_rdidx, wbck_src, arb_busy
  );

  modport slave (
    input  r0_valid, r0_info, r0_rs1, r0_rs2, r0_imm, r0_rd_en, r0_rdidx,
    input  r1_valid, r1_info, r1_rs1, r1_rs2, r1_imm, r1_rd_en, r1_rdidx,
    input  wbck_ready,
    output r0_ready, r1_ready,
    output wbck_valid, wbck_en, wbck_data, wbck_rdidx, wbck_src, arb_busy
  );
endinterface

// File: rtl/xf100_exu_alu.sv
// ----------------------------------------------------------------------------
// xf100_exu_alu
// Purely combinational integer ALU.
//   info : ALU info bus (opcode + op2-is-imm flag)
//   rs1, rs2, imm : operands
//   res  : result; add/sub wrap, slt/sltu give 0/1, lui passes imm,
//          shift opcodes yield 0
// ----------------------------------------------------------------------------
module xf100_exu_alu
  import xf100_exu_alu_arb_pkg::*;
#(
  parameter int XLEN   = XF100_XLEN,
  parameter int INFO_W = ALU_INFO_WIDTH
)(
  input  logic [INFO_W-1:0] info,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  input  logic [XLEN-1:0]   imm,
  output logic [XLEN-1:0]   res
);
  logic [XLEN-1:0] op2_s;
  alu_op_e         op_s;

  assign op2_s = info[ALU_INFO_OP2IMM] ? imm : rs2;
  assign op_s  = alu_op_e'(info[ALU_INFO_OP_LSB +: ALU_INFO_OP_W]);

  // Opcode decode and result select
  always_comb begin
    res = '0;
    case (op_s)
      ALU_ADD:  res = rs1 + op2_s;
      ALU_SUB:  res = rs1 - op2_s;
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(op2_s))};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, (rs1 < op2_s)};
      ALU_XOR:  res = rs1 ^ op2_s;
      ALU_OR:   res = rs1 | op2_s;
      ALU_AND:  res = rs1 & op2_s;
      ALU_LUI:  res = imm;
      ALU_SLL, ALU_SRL, ALU_SRA: res = '0;
      default:  res = '0;
    endcase
  end
endmodule

// File: rtl/xf100_exu_alu_arb.sv
// ----------------------------------------------------------------------------
// xf100_exu_alu_arb
// Round-robin arbiter sharing one xf100_exu_alu between requester r0 (decode
// issue) and r1 (helper). The granted op executes in the accept cycle and its
// result is queued in a DEPTH-entry in-order FIFO toward writeback.
//   clk, rst : clock, asynchronous active-high reset
//   flush    : synchronous flush; blocks accepts and empties the FIFO
//   bus      : request channels, writeback head, arb_busy (slave side)
// ----------------------------------------------------------------------------
module xf100_exu_alu_arb
  import xf100_exu_alu_arb_pkg::*;
#(
  parameter int XLEN    = XF100_XLEN,
  parameter int RFIDX_W = XF100_RFIDX_WIDTH,
  parameter int INFO_W  = ALU_INFO_WIDTH,
  parameter int DEPTH   = XF100_ALU_ARB_DEPTH
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  xf100_exu_alu_arb_if.slave bus
);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = XLEN + RFIDX_W + 2;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  // Entry layout {src, rd_en, rdidx, data}
  logic [ENTRY_W-1:0] fifo_mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               last_grant_r;

  logic               wbck_valid_s;
  logic               pop_s;
  logic               space_s;
  logic               grant_s;
  logic               push_s;
  logic [INFO_W-1:0]  info_s;
  logic [XLEN-1:0]    rs1_s;
  logic [XLEN-1:0]    rs2_s;
  logic [XLEN-1:0]    imm_s;
  logic               rd_en_s;
  logic [RFIDX_W-1:0] rdidx_s;
  logic [XLEN-1:0]    alu_res_s;
  logic [ENTRY_W-1:0] head_s;

  assign wbck_valid_s = (cnt_r != '0);
  assign pop_s        = wbck_valid_s & bus.wbck_ready;
  // A full FIFO can still accept when the head leaves in the same cycle
  assign space_s      = (cnt_r < CNT_DEPTH) | pop_s;

  // Round-robin grant; the lone valid requester always wins, otherwise the
  // one that was not accepted last
  always_comb begin
    grant_s = 1'b0;
    if (bus.r0_valid && bus.r1_valid) begin
      grant_s = ~last_grant_r;
    end else if (bus.r1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign bus.r0_ready = bus.r0_valid & ~grant_s & space_s & ~flush & ~rst;
  assign bus.r1_ready = bus.r1_valid &  grant_s & space_s & ~flush & ~rst;
  assign push_s       = (bus.r0_valid & bus.r0_ready) | (bus.r1_valid & bus.r1_ready);

  // Route the granted payload into the shared ALU
  always_comb begin
    info_s  = bus.r0_info;
    rs1_s   = bus.r0_rs1;
    rs2_s   = bus.r0_rs2;
    imm_s   = bus.r0_imm;
    rd_en_s = bus.r0_rd_en;
    rdidx_s = bus.r0_rdidx;
    if (grant_s) begin
      info_s  = bus.r1_info;
      rs1_s   = bus.r1_rs1;
      rs2_s   = bus.r1_rs2;
      imm_s   = bus.r1_imm;
      rd_en_s = bus.r1_rd_en;
      rdidx_s = bus.r1_rdidx;
    end else begin
      info_s  = bus.r0_info;
      rs1_s   = bus.r0_rs1;
      rs2_s   = bus.r0_rs2;
      imm_s   = bus.r0_imm;
      rd_en_s = bus.r0_rd_en;
      rdidx_s = bus.r0_rdidx;
    end
  end

  xf100_exu_alu #(
    .XLEN   (XLEN),
    .INFO_W (INFO_W)
  ) u_alu (
    .info (info_s),
    .rs1  (rs1_s),
    .rs2  (rs2_s),
    .imm  (imm_s),
    .res  (alu_res_s)
  );

  // Result FIFO, pointers, occupancy and round-robin history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r        <= '0;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      last_grant_r <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_r[i] <= '0;
      end
    end else if (flush) begin
      // Storage is left as-is; with cnt at zero nothing in it is visible
      cnt_r    <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {grant_s, rd_en_s, rdidx_s, alu_res_s};
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
        last_grant_r         <= grant_s;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push_s && !pop_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
        cnt_r <= cnt_r - CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign head_s         = fifo_mem_r[rd_ptr_r];
  assign bus.wbck_valid = wbck_valid_s;
  assign bus.wbck_src   = head_s[ENTRY_W-1];
  assign bus.wbck_en    = head_s[ENTRY_W-2];
  assign bus.wbck_rdidx = head_s[XLEN +: RFIDX_W];
  assign bus.wbck_data  = head_s[XLEN-1:0];
  assign bus.arb_busy   = wbck_valid_s;
endmodule

// File: tb/tb_xf100_exu_alu_arb.sv
// ----------------------------------------------------------------------------
// tb_xf100_exu_alu_arb
// Self-checking bench for xf100_exu_alu_arb. A negedge monitor keeps a
// reference model of grant/occupancy and a queue of expected results; the
// main thread drives directed scenarios and adds point checks.
// ----------------------------------------------------------------------------
module tb_xf100_exu_alu_arb;
  import xf100_exu_alu_arb_pkg::*;

  typedef struct packed {
    logic        src;
    logic        en;
    logic [4:0]  rdidx;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  logic flush;
  int   n_vec;
  int   n_err;
  exp_t q[$];

  // monitor model state
  logic m_last;
  logic m_valid;
  logic m_pop;
  logic m_space;
  logic m_g;
  logic m_rdy0;
  logic m_rdy1;
  exp_t m_e;
  exp_t m_head;

  xf100_exu_alu_arb_if bus ();

  xf100_exu_alu_arb dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] info, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
    logic [31:0] o2;
    o2 = info[4] ? imm : b;
    case (info[3:0])
      4'd0:    return a + o2;
      4'd1:    return a - o2;
      4'd2:    return ($signed(a) < $signed(o2)) ? 32'd1 : 32'd0;
      4'd3:    return (a < o2) ? 32'd1 : 32'd0;
      4'd4:    return a ^ o2;
      4'd5:    return a | o2;
      4'd6:    return a & o2;
      4'd7:    return imm;
      default: return 32'd0;
    endcase
  endfunction

  // Reference model and scoreboard, evaluated mid-cycle while inputs are stable
  always @(negedge clk) begin
    if (rst) begin
      check_eq("rst_wbck_valid", {31'b0, bus.wbck_valid}, 32'd0);
      check_eq("rst_r0_ready", {31'b0, bus.r0_ready}, 32'd0);
      check_eq("rst_r1_ready", {31'b0, bus.r1_ready}, 32'd0);
      q.delete();
      m_last = 1'b1;
    end else begin
      m_valid = (q.size() != 0);
      m_pop   = m_valid && bus.wbck_ready;
      m_space = (q.size() < 2) || m_pop;
      if (bus.r0_valid && bus.r1_valid) m_g = ~m_last;
      else if (bus.r1_valid)            m_g = 1'b1;
      else                              m_g = 1'b0;
      m_rdy0 = bus.r0_valid && !m_g && m_space && !flush;
      m_rdy1 = bus.r1_valid &&  m_g && m_space && !flush;
      check_eq("wbck_valid", {31'b0, bus.wbck_valid}, {31'b0, m_valid});
      check_eq("arb_busy", {31'b0, bus.arb_busy}, {31'b0, m_valid});
      check_eq("r0_ready", {31'b0, bus.r0_ready}, {31'b0, m_rdy0});
      check_eq("r1_ready", {31'b0, bus.r1_ready}, {31'b0, m_rdy1});
      if (m_valid) begin
        m_head = q[0];
        check_eq("wbck_data", bus.wbck_data, m_head.data);
        check_eq("wbck_rdidx", {27'b0, bus.wbck_rdidx}, {27'b0, m_head.rdidx});
        check_eq("wbck_en", {31'b0, bus.wbck_en}, {31'b0, m_head.en});
        check_eq("wbck_src", {31'b0, bus.wbck_src}, {31'b0, m_head.src});
        if (m_pop) void'(q.pop_front());
      end
      if (flush) begin
        q.delete();
      end else if (m_rdy0 || m_rdy1) begin
        if (m_g) begin
          m_e.src   = 1'b1;
          m_e.en    = bus.r1_rd_en;
          m_e.rdidx = bus.r1_rdidx;
          m_e.data  = ref_alu(bus.r1_info, bus.r1_rs1, bus.r1_rs2, bus.r1_imm);
        end else begin
          m_e.src   = 1'b0;
          m_e.en    = bus.r0_rd_en;
          m_e.rdidx = bus.r0_rdidx;
          m_e.data  = ref_alu(bus.r0_info, bus.r0_rs1, bus.r0_rs2, bus.r0_imm);
        end
        q.push_back(m_e);
        m_last = m_g;
      end
    end
  end

  task automatic drive_req(input bit which, input logic [4:0] info, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm,
                           input logic en, input logic [4:0] idx);
    if (which) begin
      bus.r1_valid = 1'b1; bus.r1_info = info; bus.r1_rs1 = a; bus.r1_rs2 = b;
      bus.r1_imm = imm; bus.r1_rd_en = en; bus.r1_rdidx = idx;
    end else begin
      bus.r0_valid = 1'b1; bus.r0_info = info; bus.r0_rs1 = a; bus.r0_rs2 = b;
      bus.r0_imm = imm; bus.r0_rd_en = en; bus.r0_rdidx = idx;
    end
  endtask

  // Hold the request until accepted (bounded), then drop valid
  task automatic wait_acc(input bit which);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = which ? bus.r1_ready : bus.r0_ready;
      @(posedge clk);
      #1;
    end
    check_eq("accept_in_budget", {31'b0, got}, 32'd1);
    if (which) bus.r1_valid = 1'b0;
    else       bus.r0_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [4:0]  t_info [5];
  logic [31:0] t_a    [5];
  logic [31:0] t_b    [5];
  logic        t_en   [5];
  bit a0, a1, prev_a1;

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0; m_last = 1'b1;
    rst = 1'b1; flush = 1'b0;
    bus.r0_valid = 1'b0; bus.r0_info = '0; bus.r0_rs1 = '0; bus.r0_rs2 = '0;
    bus.r0_imm = '0; bus.r0_rd_en = 1'b0; bus.r0_rdidx = '0;
    bus.r1_valid = 1'b0; bus.r1_info = '0; bus.r1_rs1 = '0; bus.r1_rs2 = '0;
    bus.r1_imm = '0; bus.r1_rd_en = 1'b0; bus.r1_rdidx = '0;
    bus.wbck_ready = 1'b0;
    cycles(2);
    check_eq("reset_data", bus.wbck_data, 32'd0);
    rst = 1'b0;

    // 1: single ADD, one-cycle latency, FIFO empties after pop
    bus.wbck_ready = 1'b1;
    drive_req(1'b0, alu_info(ALU_ADD, 1'b0), 32'd5, 32'd7, 32'd0, 1'b1, 5'd3);
    wait_acc(1'b0);
    @(negedge clk);
    check_eq("t1_valid", {31'b0, bus.wbck_valid}, 32'd1);
    check_eq("t1_data", bus.wbck_data, 32'd12);
    check_eq("t1_rdidx", {27'b0, bus.wbck_rdidx}, 32'd3);
    check_eq("t1_src", {31'b0, bus.wbck_src}, 32'd0);
    @(negedge clk);
    check_eq("t1_empty", {31'b0, bus.arb_busy}, 32'd0);
    cycles(1);

    // 2: both requesters valid continuously -> alternating grants
    drive_req(1'b0, alu_info(ALU_ADD, 1'b1), 32'd1, 32'd0, 32'd2, 1'b1, 5'd4);
    drive_req(1'b1, alu_info(ALU_SLTU, 1'b0), 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 5'd5);
    prev_a1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a0 = bus.r0_ready; a1 = bus.r1_ready;
      if (i < 4) check_eq("rr_one_grant", {31'b0, a0 ^ a1}, 32'd1);
      if (i > 0 && i < 4) check_eq("rr_alternate", {31'b0, a0}, {31'b0, prev_a1});
      prev_a1 = a1;
      @(posedge clk); #1;
      if (i >= 3) begin
        if (a0) bus.r0_valid = 1'b0;
        if (a1) bus.r1_valid = 1'b0;
      end
    end
    cycles(3);

    // 3: backpressure; third op waits and enters with the first pop
    bus.wbck_ready = 1'b0;
    drive_req(1'b0, alu_info(ALU_SUB, 1'b0), 32'd10, 32'd3, 32'd0, 1'b1, 5'd6);
    wait_acc(1'b0);
    drive_req(1'b0, alu_info(ALU_XOR, 1'b0), 32'hA5A5_A5A5, 32'hFFFF_0000, 32'd0, 1'b1, 5'd7);
    wait_acc(1'b0);
    drive_req(1'b0, alu_info(ALU_LUI, 1'b1), 32'd9, 32'd9, 32'h1234_5000, 1'b0, 5'd8);
    @(negedge clk);
    check_eq("t3_full_stall", {31'b0, bus.r0_ready}, 32'd0);
    @(negedge clk);
    check_eq("t3_hold_data", bus.wbck_data, 32'd7);
    @(posedge clk); #1;
    bus.wbck_ready = 1'b1;
    @(negedge clk);
    check_eq("t3_accept_on_pop", {31'b0, bus.r0_ready}, 32'd1);
    @(posedge clk); #1;
    bus.r0_valid = 1'b0;

    // 4: FIFO kept full with push+pop every cycle; pointers wrap
    t_info[0] = alu_info(ALU_SLT, 1'b0); t_a[0] = 32'hFFFF_FFFE; t_b[0] = 32'd1;          t_en[0] = 1'b1;
    t_info[1] = alu_info(ALU_AND, 1'b0); t_a[1] = 32'hF0F0_F0F0; t_b[1] = 32'h0FF0_0FF0;  t_en[1] = 1'b1;
    t_info[2] = alu_info(ALU_OR,  1'b0); t_a[2] = 32'h1200_0034; t_b[2] = 32'h0000_5600;  t_en[2] = 1'b1;
    t_info[3] = alu_info(ALU_SLL, 1'b0); t_a[3] = 32'd1;         t_b[3] = 32'd3;          t_en[3] = 1'b1;
    t_info[4] = alu_info(ALU_SUB, 1'b0); t_a[4] = 32'd0;         t_b[4] = 32'd1;          t_en[4] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_req(1'b1, t_info[k], t_a[k], t_b[k], 32'd0, t_en[k], 5'(k + 10));
      wait_acc(1'b1);
      check_eq("t4_busy", {31'b0, bus.arb_busy}, 32'd1);
    end
    cycles(3);

    // 5: flush with two queued and r1 requesting
    bus.wbck_ready = 1'b0;
    drive_req(1'b0, alu_info(ALU_ADD, 1'b0), 32'd100, 32'd1, 32'd0, 1'b1, 5'd20);
    wait_acc(1'b0);
    drive_req(1'b0, alu_info(ALU_ADD, 1'b0), 32'd200, 32'd2, 32'd0, 1'b1, 5'd21);
    wait_acc(1'b0);
    flush = 1'b1;
    drive_req(1'b1, alu_info(ALU_OR, 1'b1), 32'h0000_00F0, 32'd0, 32'h0000_000F, 1'b1, 5'd22);
    @(negedge clk);
    check_eq("t5_flush_r1_ready", {31'b0, bus.r1_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check_eq("t5_post_flush_valid", {31'b0, bus.wbck_valid}, 32'd0);
    @(posedge clk); #1;
    bus.r1_valid = 1'b0;
    bus.wbck_ready = 1'b1;
    @(negedge clk);
    check_eq("t5_after_flush_data", bus.wbck_data, 32'h0000_00FF);
    cycles(2);

    // 6: async reset with an entry queued; first conflict after goes to r0
    bus.wbck_ready = 1'b0;
    drive_req(1'b0, alu_info(ALU_AND, 1'b0), 32'hFFFF_FFFF, 32'h0000_1234, 32'd0, 1'b1, 5'd23);
    wait_acc(1'b0);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_valid_now", {31'b0, bus.wbck_valid}, 32'd0);
    check_eq("t6_rst_busy_now", {31'b0, bus.arb_busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_req(1'b0, alu_info(ALU_ADD, 1'b0), 32'd40, 32'd2, 32'd0, 1'b1, 5'd24);
    drive_req(1'b1, alu_info(ALU_SUB, 1'b0), 32'd40, 32'd2, 32'd0, 1'b1, 5'd25);
    @(negedge clk);
    check_eq("t6_first_grant_r0", {31'b0, bus.r0_ready}, 32'd1);
    check_eq("t6_first_grant_r1", {31'b0, bus.r1_ready}, 32'd0);
    @(posedge clk); #1;
    bus.r0_valid = 1'b0;
    wait_acc(1'b1);
    bus.wbck_ready = 1'b1;
    cycles(4);

    check_eq("final_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/xf100_exu_alu_arb.md
Name: xf100_exu_alu_arb

Overview:
Shares the single combinational ALU (xf100_exu_alu) between two requesters: the decode issue path (r0) and a secondary execute requester (r1, e.g. address/compare helper).
- Arbitrates with round-robin, executes the granted op in the same cycle, and buffers results in a 2-entry in-order FIFO toward writeback.
- Sits between dispatch/helper units and the writeback arbiter in the EXU.

Parameters:
XLEN, 32, operand/result width (tied to XF100_XLEN)
RFIDX_W, 5, register index width (tied to XF100_RFIDX_WIDTH)
INFO_W, ALU_INFO_WIDTH, ALU info bus width
DEPTH, 2, result FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous pipeline flush
rN_valid  in  1  request valid, N=0,1
rN_ready  out  1  request accepted this cycle, N=0,1
rN_info  in  INFO_W  ALU info bus, N=0,1
rN_rs1, rN_rs2, rN_imm  in  XLEN  operands/immediate, N=0,1
rN_rd_en  in  1  writeback enable, N=0,1
rN_rdidx  in  RFIDX_W  destination index, N=0,1
wbck_valid  out  1  head result valid
wbck_ready  in  1  writeback consumes head
wbck_en  out  1  head rd_en
wbck_data  out  XLEN  head result
wbck_rdidx  out  RFIDX_W  head destination
wbck_src  out  1  requester that produced head (0/1)
arb_busy  out  1  FIFO non-empty

Behaviour:
- Reset (async, rst=1): cnt=0, rd/wr ptr=0, last_grant=1 (r0 wins the first conflict), all FIFO storage 0. wbck_valid=0, wbck_*=0, rN_ready=0, arb_busy=0.
- pop = wbck_valid & wbck_ready.
- space = (cnt<DEPTH) | pop. Full-with-pop accepts a new request.
- Grant, combinational:
  - Only one valid: grant it.
  - Both valid: grant ~last_grant.
  - Grant is independent of ready. A requester must hold valid/payload until ready.
- rN_ready = grantN & space & ~flush. It may depend on rN_valid; valid must never depend on ready.
- Accept (push) = rN_valid & rN_ready.
  - Granted payload muxed into one ALU instance; result written to FIFO tail with rd_en, rdidx, src.
  - last_grant updates to the accepted requester only on accept.
- Latency: accept in cycle T produces wbck_valid in T+1 if the FIFO was empty. Results are strictly in accept order.
- Head outputs hold stable while wbck_valid & ~wbck_ready.
- cnt update: push&~pop +1, pop&~push -1, both unchanged. Pointers wrap modulo DEPTH.
- Entries with rd_en=0 still flow through with wbck_en=0.
- flush=1:
  - No accept; FIFO emptied: cnt/ptrs to 0.
  - wbck_valid=0 from next cycle. A pop in the flush cycle is still honoured by the consumer.
  - last_grant unchanged.
- Reset mid-operation: all in-flight results discarded immediately (async). No output glitch requirement beyond reset values.
- ALU semantics as xf100_exu_alu: add/sub mod 2^XLEN, slt/sltu 0/1, logic ops, lui=imm. Shifts are unsupported and produce 0.
- arb_busy = (cnt!=0).

Decomposition:
- ALU_INFO bit indices and ALU_INFO_WIDTH stay in xf100_defines.v.
- Add XF100_ALU_ARB_DEPTH there.
- One sub-module instance: xf100_exu_alu (unchanged) for the datapath.
- FIFO is inline: storage array + ptrs + cnt.
- Entry fields: {src, rd_en, rdidx, data}.

Test Plan:
- r0 ADD rs1=5 rs2=7 rd_en=1 rdidx=3, wbck_ready=1 -> next cycle wbck_valid=1, data=12, rdidx=3, src=0. FIFO empty the cycle after.
- r0 and r1 both valid continuously (r0 ADDI 1+imm 2, r1 SLTU 1 vs 0xFFFFFFFF), ready=1 -> accepts alternate src 0,1,0,1. Data 3 and 1 respectively.
- wbck_ready=0, r0 issues 3 ops -> two accepted, then r0_ready=0. Raise wbck_ready -> third accepted in the same cycle as the first pop; order preserved.
- FIFO full, push and pop same cycle -> cnt stays 2, pointers wrap correctly across 4+ ops.
- Two entries queued, flush=1 with r1_valid=1 -> r1_ready=0 that cycle; next cycle wbck_valid=0, cnt=0. Subsequent r1 op delivered normally.
- rst asserted mid-stream with one entry queued -> wbck_valid=0 immediately. After release, first conflict grants r0.
